// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch unit feeding decode through a small queue.
// Requests are issued against a credit count (occupancy + in-flight) so the
// queue can never overflow; a redirect flushes everything and restarts fetch.
// Optional feature: define FETCH_BYPASS_EN to present an arriving response
// combinationally when the queue is empty (one cycle less fetch latency).
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iClk,
  input  logic        iRst,
  output logic        oImemReq,
  output logic [31:0] oImemAddr,
  input  logic [31:0] iImemData,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  input  logic        iReady,
  output logic        oValid,
  output logic [31:0] oInstr,
  output logic [31:0] oPC
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          epoch_q, epoch_d;
  logic          infl_q;
  logic [31:0]   infl_addr_q;
  logic          infl_epoch_q;

  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc    [DEPTH];

  logic q_nonempty;
  logic resp_ok;
  logic credit_ok;
  logic byp_valid;
  logic byp_take;
  logic q_pop;
  logic push;
  logic redirect_lsb_unused;

  // Redirect targets are forced word-aligned; the low bits are dropped.
  assign redirect_lsb_unused = ^iRedirectPC[1:0];

  assign q_nonempty = (count_q != '0);
  // A response is only usable if it belongs to the current epoch and no
  // flush is happening right now.
  assign resp_ok    = infl_q && (infl_epoch_q == epoch_q) && !iRedirect;
  // Credits use registered state only, so a pop at full frees a slot for
  // the following cycle, never the current one.
  assign credit_ok  = ({1'b0, count_q} + {{CW{1'b0}}, infl_q}) < DEPTH_C;
  assign oImemReq   = iRst && !iRedirect && credit_ok;
  assign oImemAddr  = fpc_q;

`ifdef FETCH_BYPASS_EN
  assign byp_valid = resp_ok && !q_nonempty;
`else
  assign byp_valid = 1'b0;
`endif

  assign byp_take = byp_valid && iReady;
  assign q_pop    = q_nonempty && iReady && !iRedirect;
  assign push     = resp_ok && !byp_take;
  assign oValid   = q_nonempty || byp_valid;

  // Head presentation: queue head first, else a bypassed response, else zero.
  always_comb begin
    oInstr = '0;
    oPC    = '0;
    if (q_nonempty) begin
      oInstr = mem_instr[head_q];
      oPC    = mem_pc[head_q];
    end else if (byp_valid) begin
      oInstr = iImemData;
      oPC    = infl_addr_q;
    end
  end

  // Next-state for fetch PC, queue pointers, occupancy and epoch.
  always_comb begin
    fpc_d   = fpc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    epoch_d = epoch_q;
    if (iRedirect) begin
      fpc_d   = {iRedirectPC[31:2], 2'b00};
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      epoch_d = ~epoch_q;
    end else begin
      if (oImemReq) fpc_d = fpc_q + 32'd4;
      if (push)     tail_d = tail_q + 1'b1;
      if (q_pop)    head_d = head_q + 1'b1;
      case ({push, q_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; in-flight tracking records what was issued this cycle.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      fpc_q        <= RESET_PC;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      epoch_q      <= 1'b0;
      infl_q       <= 1'b0;
      infl_addr_q  <= '0;
      infl_epoch_q <= 1'b0;
    end else begin
      fpc_q        <= fpc_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      epoch_q      <= epoch_d;
      infl_q       <= oImemReq;
      infl_addr_q  <= fpc_q;
      infl_epoch_q <= epoch_q;
    end
  end

  // Entry storage; contents are don't-care until marked valid by occupancy.
  always_ff @(posedge iClk) begin
    if (push) begin
      mem_instr[tail_q] <= iImemData;
      mem_pc[tail_q]    <= infl_addr_q;
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port iClk  input  1  rising-edge clock.
REQ-005 SHALL have port iRst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port oImemReq  output  1  instruction memory read request this cycle.
REQ-007 SHALL have port oImemAddr  output  32  word-aligned fetch address, valid with oImemReq.
REQ-008 SHALL have port iImemData  input  32  read data, returned exactly one cycle after the request.
REQ-009 SHALL have port iRedirect  input  1  taken branch/jump from execute; flush and refetch.
REQ-010 SHALL have port iRedirectPC  input  32  redirect target, sampled when iRedirect=1.
REQ-011 SHALL have port iReady  input  1  decode accepts the head entry.
REQ-012 SHALL have port oValid  output  1  head entry present.
REQ-013 SHALL have port oInstr  output  32  head instruction.
REQ-014 SHALL have port oPC  output  32  address of head instruction.

Function
REQ-015 SHALL hold fetch PC register fpc; oImemAddr = fpc; fpc += 4 mod 2^32 on each issued request (wrap 32'hFFFF_FFFC -> 0).
REQ-016 SHALL assert oImemReq only when occupancy + in-flight < DEPTH (credit rule); the queue never overflows.
REQ-017 SHALL write {iImemData, address} into the tail the cycle after the request, tagged with the address that was issued.
REQ-018 SHALL complete a pop when oValid && iReady at a rising edge; oInstr/oPC then show the next entry.
REQ-019 SHALL allow push and pop in the same cycle, occupancy unchanged; at full, a same-cycle pop frees a credit usable next cycle only.
REQ-020 SHALL keep oValid, oInstr, oPC stable while oValid && !iReady.
REQ-021 SHALL on iRedirect: empty the queue, discard the in-flight response (epoch bit toggles; stale-epoch data not written), set fpc = {iRedirectPC[31:2],2'b00}; oImemReq deasserted in the redirect cycle, first request at the target on the next cycle.
REQ-022 SHALL give iRedirect priority over a simultaneous pop and push; oValid=0 the cycle after redirect.
REQ-023 SHALL, back-to-back redirects, honour only the latest target.
REQ-024 SHALL, without bypass, show an instruction on oValid two cycles after its request (request N, data N+1, oValid N+2).
REQ-025 SHALL sustain one instruction per cycle when iReady=1 continuously.

Reset
REQ-026 SHALL while iRst=0 force fpc=RESET_PC, occupancy=0, in-flight=0, epoch=0, oImemReq=0, oValid=0, oInstr=0, oPC=0.
REQ-027 SHALL on assertion mid-operation drop all entries and any in-flight response immediately; first request at RESET_PC in the first cycle after iRst rises.

Configuration
REQ-028 SHALL support macro FETCH_BYPASS_EN.
REQ-029 SHALL with FETCH_BYPASS_EN defined, when the queue is empty and a current-epoch response arrives, drive it combinationally on oInstr/oPC with oValid=1 that cycle (oValid at N+1); if also popped it is not written.
REQ-030 SHALL without FETCH_BYPASS_EN, route every response through the queue (oValid at N+2, all outputs from registers).

Verification
REQ-031 SHALL cover reset release, iReady=1, ROM word i = 32'h1000_0000+i: oPC sequence 0,4,8,... one per cycle, first oValid at cycle 2 (cycle 1 with FETCH_BYPASS_EN).
REQ-032 SHALL cover iReady=0 for 10 cycles: exactly DEPTH=4 requests issued, oImemReq then 0, head stays oPC=0; iReady=1 resumes in order with no loss or duplicate.
REQ-033 SHALL cover iRedirect with iRedirectPC=32'h0000_0043 while queue holds 3 entries and one in flight: next oValid entry oPC=32'h0000_0040, no stale instruction ever presented.
REQ-034 SHALL cover RESET_PC=32'hFFFF_FFF8: oPC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 SHALL cover iRst=0 asserted with queue full and request in flight: outputs zero asynchronously; after release first oPC=RESET_PC.
REQ-036 SHALL cover iRedirect coincident with pop and push on a full queue: queue empty next cycle, only target-address entries follow.
